// File: rtl/GAM_package.sv
// Shared types for the node-memory arbiter: access type, FSM states,
// requester indices and a one-hot helper.
package GAM_package;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } RD_WR_T;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_LOCKED = 2'd2
  } ARB_STATE_T;

  localparam int N_REQ      = 3;
  localparam int REQ_LEARN  = 0;
  localparam int REQ_ASSOC  = 1;
  localparam int REQ_RECALL = 2;

  function automatic logic [N_REQ-1:0] idx2oh(
    input logic [1:0] idx
  );
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/node_arb_select.sv
// Winner select: first eligible requester searching upward from pointer.
// Ports: req, mask, pointer in; onehot, index out.
module node_arb_select
  import GAM_package::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [1:0]       pointer,
  output logic [N_REQ-1:0] onehot,
  output logic [1:0]       index
);

  function automatic int rot(
    input logic [1:0] p,
    input int         i
  );
    return (int'(p) + i) % N_REQ;
  endfunction

  logic [N_REQ-1:0] cand;
  logic             found;

  always_comb begin
    cand   = req & ~mask;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && cand[rot(pointer, i)]) begin
        found                    = 1'b1;
        onehot[rot(pointer, i)]  = 1'b1;
        index                    = 2'(rot(pointer, i));
      end
    end
  end

endmodule

// File: rtl/node_memory_arbiter.sv
// Three-requester node-memory arbiter with lock, lock timeout and read-valid
// return. Ports: clk, reset(async low), req/lock/rd_wr/addr/wdata per
// requester in; gnt, mem_en, mem_rd_wr, mem_addr, mem_wdata, rdata_valid,
// lock_timeout, busy out. Define NODE_ARB_ROUND_ROBIN_EN for round-robin,
// otherwise fixed priority bit0 > bit1 > bit2.
module node_memory_arbiter
  import GAM_package::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [2:0]          lock,
  input  logic [2:0]          rd_wr,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic                mem_en,
  output logic                mem_rd_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [2:0]          rdata_valid,
  output logic                lock_timeout,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

  ARB_STATE_T        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [2:0]        excl_q, excl_d;
  logic [2:0]        rv_q, rv_d;
  logic              to_q, to_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;
  logic              rw_hold_q, rw_hold_d;

  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_rw;
  logic              own_req;
  logic              own_lock;

  logic [2:0]        mask;
  logic [1:0]        ptr;
  logic [2:0]        win_oh;
  logic [1:0]        win_idx;

  always_comb begin
    own_addr  = addr[ADDR_W-1:0];
    own_wdata = wdata[DATA_W-1:0];
    own_rw    = rd_wr[REQ_LEARN];
    own_req   = req[REQ_LEARN];
    own_lock  = lock[REQ_LEARN];
    case (owner_q)
      2'(REQ_ASSOC): begin
        own_addr  = addr[ADDR_W +: ADDR_W];
        own_wdata = wdata[DATA_W +: DATA_W];
        own_rw    = rd_wr[REQ_ASSOC];
        own_req   = req[REQ_ASSOC];
        own_lock  = lock[REQ_ASSOC];
      end
      2'(REQ_RECALL): begin
        own_addr  = addr[2*ADDR_W +: ADDR_W];
        own_wdata = wdata[2*DATA_W +: DATA_W];
        own_rw    = rd_wr[REQ_RECALL];
        own_req   = req[REQ_RECALL];
        own_lock  = lock[REQ_RECALL];
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != ARB_IDLE);
  assign gnt          = busy ? idx2oh(owner_q) : 3'b000;
  assign mem_en       = busy & own_req;
  assign mem_addr     = busy ? own_addr : addr_hold_q;
  assign mem_wdata    = busy ? own_wdata : wdata_hold_q;
  assign mem_rd_wr    = busy ? own_rw : rw_hold_q;
  assign rdata_valid  = rv_q;
  assign lock_timeout = to_q;

  // A timed-out owner sits out only if someone else is asking.
  assign mask = ((req & ~excl_q) != 3'b000) ? excl_q : 3'b000;

`ifdef NODE_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  // Next search start is the slot after the new owner.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ARB_IDLE && |win_oh)
      ptr_d = {win_oh[1], win_oh[0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
`else
  assign ptr = 2'd0;
`endif

  node_arb_select u_sel (
    .req     (req),
    .mask    (mask),
    .pointer (ptr),
    .onehot  (win_oh),
    .index   (win_idx)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    excl_d       = excl_q;
    to_d         = 1'b0;
    rv_d         = (mem_en && own_rw == READ) ? gnt : 3'b000;
    addr_hold_d  = mem_addr;
    wdata_hold_d = mem_wdata;
    rw_hold_d    = mem_rd_wr;
    case (state_q)
      ARB_IDLE: begin
        if (|win_oh) begin
          state_d    = ARB_GRANT;
          owner_d    = win_idx;
          lock_cnt_d = '0;
          excl_d     = 3'b000;
        end
      end
      ARB_GRANT: begin
        state_d = own_lock ? ARB_LOCKED : ARB_IDLE;
      end
      ARB_LOCKED: begin
        if (!own_lock) begin
          state_d = ARB_IDLE;
        end else if (lock_cnt_q >= CNT_MAX) begin
          state_d = ARB_IDLE;
          to_d    = 1'b1;
          excl_d  = gnt;
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= 2'd0;
      lock_cnt_q   <= '0;
      excl_q       <= 3'b000;
      rv_q         <= 3'b000;
      to_q         <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rw_hold_q    <= READ;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      excl_q       <= excl_d;
      rv_q         <= rv_d;
      to_q         <= to_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
      rw_hold_q    <= rw_hold_d;
    end
  end

endmodule

// File: tb/tb_node_memory_arbiter.sv
// Self-checking bench for node_memory_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_node_memory_arbiter;

  localparam int MAXL = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  req, lock, rd_wr;
  logic [23:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic        mem_en, mem_rd_wr;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [2:0]  rdata_valid;
  logic        lock_timeout, busy;

  int n_cmp;
  int n_fail;

  node_memory_arbiter #(
    .ADDR_W(8), .DATA_W(16), .MAX_LOCK(MAXL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .rd_wr(rd_wr),
    .addr(addr), .wdata(wdata), .gnt(gnt), .mem_en(mem_en),
    .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rdata_valid(rdata_valid), .lock_timeout(lock_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 first access, 2 held by lock.
  int          m_phase, m_owner, m_held, m_excl, m_start, m_rv;
  logic        m_to;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic        m_rw;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_held = 0; m_excl = -1;
    m_start = 0; m_rv = -1; m_to = 1'b0;
    m_addr = '0; m_wdata = '0; m_rw = 1'b0;
  endtask

  task automatic model_step();
    int  w, c;
    bit  en;
    en = (m_phase != 0) && req[m_owner];
    if (m_phase != 0) begin
      m_addr  = addr[m_owner*8 +: 8];
      m_wdata = wdata[m_owner*16 +: 16];
      m_rw    = rd_wr[m_owner];
    end
    m_rv = (en && rd_wr[m_owner] == 1'b0) ? m_owner : -1;
    m_to = 1'b0;
    if (m_phase == 0) begin
      if (req != 3'b000) begin
        w = -1;
        for (int k = 0; k < 3; k++) begin
          c = (m_start + k) % 3;
          if (w < 0 && req[c] &&
              !(c == m_excl && (req & ~(3'b001 << c)) != 3'b000))
            w = c;
        end
        m_owner = w;
        m_phase = 1;
        m_excl  = -1;
`ifdef NODE_ARB_ROUND_ROBIN_EN
        m_start = (w + 1) % 3;
`endif
      end
    end else if (m_phase == 1) begin
      m_phase = lock[m_owner] ? 2 : 0;
      m_held  = 0;
    end else begin
      if (!lock[m_owner]) begin
        m_phase = 0;
      end else if (m_held >= MAXL - 1) begin
        m_phase = 0;
        m_to    = 1'b1;
        m_excl  = m_owner;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; rd_wr = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (gnt !== 3'b000 || busy !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl gnt=%b busy=%b en=%b want 000/0/0",
               gnt, busy, mem_en);
    end
    n_cmp++;
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h0 || mem_rd_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem addr=%h wdata=%h rw=%b want 00/0000/0",
               mem_addr, mem_wdata, mem_rd_wr);
    end
    n_cmp++;
    if (rdata_valid !== 3'b000 || lock_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags rv=%b to=%b want 000/0",
               rdata_valid, lock_timeout);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    req = 3'b001; rd_wr = 3'b000; addr[7:0] = 8'h12;
    tick();
    #1;
    n_cmp++;
    if (gnt !== 3'b001 || mem_addr !== 8'h12 || mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant gnt=%b addr=%h en=%b want 001/12/1",
               gnt, mem_addr, mem_en);
    end
    tick();
    req = 3'b000;
    #1;
    n_cmp++;
    if (rdata_valid !== 3'b001 || busy !== 1'b0 || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL single_rv rv=%b busy=%b gnt=%b want 001/0/000",
               rdata_valid, busy, gnt);
    end
    n_cmp++;
    if (mem_addr !== 8'h12) begin
      n_fail++;
      $display("FAIL idle_hold addr=%h want 12", mem_addr);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_seq [4];
    int         g;
`ifdef NODE_ARB_ROUND_ROBIN_EN
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    g = 0;
    req = 3'b111; rd_wr = 3'b111;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (gnt !== 3'b000 && g < 4) begin
        n_cmp++;
        if (gnt !== exp_seq[g]) begin
          n_fail++;
          $display("FAIL simul_grant%0d got=%b want=%b", g, gnt, exp_seq[g]);
        end
        g++;
      end
      tick();
    end
    n_cmp++;
    if (g != 4) begin
      n_fail++;
      $display("FAIL simul_count got=%0d want=4", g);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_lock();
    int         writes;
    logic [15:0] wd;
    writes = 0;
    req = 3'b010; lock = 3'b010; rd_wr = 3'b010;
    tick();
    for (int k = 0; k < 5; k++) begin
      wd = 16'($urandom);
      addr[15:8]   = 8'(k);
      wdata[31:16] = wd;
      lock = (k < 4) ? 3'b010 : 3'b000;
      #1;
      n_cmp++;
      if (gnt !== 3'b010 || mem_rd_wr !== 1'b1 || mem_addr !== 8'(k) ||
          mem_wdata !== wd) begin
        n_fail++;
        $display("FAIL lock_access%0d gnt=%b rw=%b addr=%h wd=%h want 010/1/%h/%h",
                 k, gnt, mem_rd_wr, mem_addr, mem_wdata, 8'(k), wd);
      end
      if (mem_en === 1'b1) writes++;
      tick();
    end
    clear_inputs();
    #1;
    n_cmp++;
    if (writes != 5 || busy !== 1'b0 || lock_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_end writes=%0d busy=%b to=%b want 5/0/0",
               writes, busy, lock_timeout);
    end
    tick();
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    req = 3'b100; lock = 3'b100;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 1) req = 3'b101;
      #1;
      if (lock_timeout === 1'b1) pulses++;
      if (k == 4) begin
        n_cmp++;
        if (gnt !== 3'b100 || lock_timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL to_held gnt=%b to=%b want 100/0", gnt, lock_timeout);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (lock_timeout !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL to_pulse to=%b busy=%b want 1/0", lock_timeout, busy);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (gnt !== 3'b001) begin
          n_fail++;
          $display("FAIL to_next_grant got=%b want=001", gnt);
        end
      end
      tick();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL to_count got=%0d want=1", pulses);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_bubble();
    logic pat [3];
    pat = '{1'b1, 1'b0, 1'b1};
    req = 3'b001; lock = 3'b001; rd_wr = 3'b001;
    tick();
    for (int k = 0; k < 3; k++) begin
      req  = {2'b00, pat[k]};
      lock = (k < 2) ? 3'b001 : 3'b000;
      #1;
      n_cmp++;
      if (mem_en !== pat[k] || gnt !== 3'b001) begin
        n_fail++;
        $display("FAIL bubble%0d en=%b gnt=%b want %b/001",
                 k, mem_en, gnt, pat[k]);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_lock();
    int pulses;
    pulses = 0;
    req = 3'b010; lock = 3'b010;
    tick();
    tick();
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midlock_busy got=%b want=1", busy);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 3'b000 || busy !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midlock_async gnt=%b busy=%b en=%b want 000/0/0",
               gnt, busy, mem_en);
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (lock_timeout === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midlock_timeout got=%0d want=0", pulses);
    end
    clear_inputs();
    model_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  eg, erv;
    logic        een, erw;
    logic [7:0]  ea;
    logic [15:0] ew;
    bit          ebusy;
    for (int k = 0; k < 400; k++) begin
      req   = 3'($urandom);
      rd_wr = 3'($urandom);
      addr  = 24'($urandom);
      wdata = {16'($urandom), 16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 3) == 0) lock = 3'($urandom);
      #1;
      ebusy = (m_phase != 0);
      eg    = ebusy ? (3'b001 << m_owner) : 3'b000;
      een   = ebusy && req[m_owner];
      ea    = ebusy ? addr[m_owner*8 +: 8] : m_addr;
      ew    = ebusy ? wdata[m_owner*16 +: 16] : m_wdata;
      erw   = ebusy ? rd_wr[m_owner] : m_rw;
      erv   = (m_rv >= 0) ? (3'b001 << m_rv) : 3'b000;
      n_cmp++;
      if (gnt !== eg || busy !== ebusy || mem_en !== een) begin
        n_fail++;
        $display("FAIL rnd_ctl%0d gnt=%b busy=%b en=%b want %b/%b/%b",
                 k, gnt, busy, mem_en, eg, ebusy, een);
      end
      n_cmp++;
      if (mem_addr !== ea || mem_wdata !== ew || mem_rd_wr !== erw) begin
        n_fail++;
        $display("FAIL rnd_mem%0d addr=%h wd=%h rw=%b want %h/%h/%b",
                 k, mem_addr, mem_wdata, mem_rd_wr, ea, ew, erw);
      end
      n_cmp++;
      if (rdata_valid !== erv || lock_timeout !== m_to) begin
        n_fail++;
        $display("FAIL rnd_flags%0d rv=%b to=%b want %b/%b",
                 k, rdata_valid, lock_timeout, erv, m_to);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clk    = 1'b0;
    reset  = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    tick();
    test_single_read();
    do_reset();
    test_simultaneous();
    test_lock();
    test_timeout();
    test_bubble();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/node_memory_arbiter.md
NODE_MEMORY_ARBITER -- requirements
Module: node_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, node-memory address width.
REQ-002 Parameter DATA_W, default 16, node-memory word width.
REQ-003 Parameter MAX_LOCK, default 64, maximum consecutive locked-grant cycles.
REQ-004 The block SHALL have one clock, clk, and reset SHALL be asynchronous and active-low.
REQ-005 Ports, in this order:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- req  in  3  per-requester request. Bit 0 is the memory-layer learning controller, bit 1 the associative learner, bit 2 the recall engine.
- lock  in  3  per-requester hold-grant across a multi-cycle sequence.
- rd_wr  in  3  per-requester access type, RD_WR_T encoding.
- addr  in  3*ADDR_W  packed per-requester addresses.
- wdata  in  3*DATA_W  packed per-requester write data.
- gnt  out  3  one-hot grant.
- mem_en  out  1  node-memory access strobe.
- mem_rd_wr  out  1  RD_WR_T to node memory.
- mem_addr  out  ADDR_W  address to node memory.
- mem_wdata  out  DATA_W  write data to node memory.
- rdata_valid  out  3  one-hot; node-memory read data is valid for that requester.
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly broken.
- busy  out  1  high in any state other than ARB_IDLE.

Function
REQ-006 The FSM SHALL have three states: ARB_IDLE, ARB_GRANT and ARB_LOCKED.
REQ-007 In ARB_IDLE with req!=0, the FSM SHALL register the winner in owner and enter ARB_GRANT the next cycle.
- Grant latency is exactly 1 cycle.
REQ-008 In ARB_GRANT and ARB_LOCKED:
- gnt[owner]=1.
- mem_en=req[owner].
- mem_addr, mem_wdata and mem_rd_wr SHALL be driven combinationally from the owner's slice.
REQ-009 From ARB_GRANT:
- lock[owner]=1 goes to ARB_LOCKED.
- Otherwise the FSM goes to ARB_IDLE after one access.
REQ-010 ARB_LOCKED SHALL persist while lock[owner]=1 and lock_cnt<MAX_LOCK-1.
- When lock[owner] falls, the FSM SHALL go to ARB_IDLE.
REQ-011 When lock_cnt reaches MAX_LOCK-1 in ARB_LOCKED:
- The FSM SHALL go to ARB_IDLE and pulse lock_timeout.
- owner SHALL be excluded from the next arbitration if any other req is high.
REQ-012 lock_cnt SHALL clear on every entry to ARB_GRANT and saturate; it SHALL NOT wrap.
REQ-013 Node-memory read latency is 1 cycle.
- rdata_valid[owner] SHALL assert the cycle after mem_en=1 with mem_rd_wr=READ.
- The issuing owner index is registered, so rdata_valid is correct even after the grant has moved.
REQ-014 In ARB_IDLE:
- gnt=0 and mem_en=0.
- mem_addr, mem_wdata and mem_rd_wr SHALL hold their last values.
REQ-015 When req[owner] drops while in ARB_LOCKED with lock still high, the FSM SHALL stay locked and mem_en=0; this is a bubble, not a release.
REQ-016 Simultaneous requests SHALL resolve per REQ-022 in a single cycle, with no lost request.
- A losing requester SHALL keep req high until it receives gnt.

Reset
REQ-017 On reset low, asynchronously:
- The FSM goes to ARB_IDLE.
- gnt, mem_en, rdata_valid, lock_timeout, busy and lock_cnt go to 0.
- owner goes to 0, mem_addr and mem_wdata to 0, mem_rd_wr to READ.
- The round-robin pointer goes to 0.
REQ-018 Reset asserted mid-lock SHALL abort the sequence and SHALL produce no lock_timeout pulse.
REQ-019 Reset release SHALL take effect on the first rising clk edge after reset goes high.

Configuration
REQ-020 Macro NODE_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-021 Without the macro, arbitration SHALL be fixed priority: bit 0 over bit 1 over bit 2.
REQ-022 With the macro, arbitration SHALL be round-robin.
- The search SHALL start at (last_owner+1) mod 3.
- The pointer SHALL update only when a grant is issued.

Structure
REQ-023 The following SHALL live in GAM_package, alongside the existing RD_WR_T:
- ARB_STATE_T.
- Requester index constants REQ_LEARN=0, REQ_ASSOC=1, REQ_RECALL=2.
REQ-024 The winner-select logic SHALL be one sub-module, node_arb_select.
- Inputs: req, mask, pointer.
- Outputs: one-hot and index.

Verification
REQ-025 Single read: req=3'b001, rd_wr=READ, addr=8'h12.
- gnt=001 at cycle+1, mem_addr=8'h12, rdata_valid=001 at cycle+2, then back to ARB_IDLE.
REQ-026 Simultaneous req=3'b111, all held, no lock:
- Fixed priority: grants 001, 001, ...
- Round-robin: grants 001, 010, 100, 001.
REQ-027 Lock sequence: req[1]=1 and lock[1]=1 for 5 cycles with writes 8'h00..8'h04.
- gnt=010 throughout and 5 consecutive mem_en writes.
- ARB_IDLE follows the lock drop.
REQ-028 Lock timeout: MAX_LOCK=4, lock[2] held, req[0] pending.
- lock_timeout pulses once after the 4th locked cycle.
- The next grant is 001.
REQ-029 Reset mid-lock: reset low during ARB_LOCKED.
- gnt=0 and busy=0 immediately, without waiting for a clk edge.
- No lock_timeout pulse.
REQ-030 Bubble: lock[0]=1 while req[0] toggles 1,0,1.
- mem_en follows 1,0,1 and gnt stays 001.
